odd_even_sort_engine: RTL and testbench
=======================================

# odd_even_sort_engine

Parametrised sequential sorter built around a row of compare-swap units running odd-even transposition sort. It loads N words of W bits serially over a valid/ready stream and sorts them in place under one of four modes: ascending, descending, odd-before-even, or parity-grouped. It then streams the result out over a second valid/ready stream. It is the buffered, multi-element successor to the 2-input swap cells, for use wherever a frame of small values must be reordered.

## Interface
- W, 4: data word width in bits (≥1).
- N, 8: elements per frame; even, ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  engine accepts input (IDLE/LOAD only).
- in_data  in  W  input word.
- mode  in  2  sort mode, sampled with first word of frame: 0 asc, 1 desc, 2 odd-first, 3 parity-grouped.
- out_valid  out  1  output word present.
- out_ready  in  1  downstream accepts output.
- out_data  out  W  output word; 0 when out_valid low.
- busy  out  1  high in SORT and OUT.

## Operation
- FSM: IDLE → LOAD → SORT → OUT → IDLE.
- IDLE: in_ready=1. First handshake stores buf[0] and latches mode, then goes to LOAD. Mode changes later in the frame are ignored.
- LOAD: in_ready=1; each handshake writes buf[idx]. The N-th handshake enters SORT on the next edge.
- SORT: one pass per cycle; pass p uses even pairs (0,1),(2,3)… when p even, odd pairs (1,2),(3,4)… when p odd. Exactly N passes; pass counter width $clog2(N)+1.
- Per-pair rule for left element a and right element b:
  - mode 0: swap if a>b.
  - mode 1: swap if a<b.
  - mode 2: swap if a even and b odd. This is stable within each parity class.
  - mode 3: swap if both odd and a>b, or both even and a<b; mixed-parity pairs are never swapped.
- OUT: out_valid=1, out_data=buf[idx], idx from 0. idx advances on out_valid&&out_ready. The N-th handshake returns the FSM to IDLE on the next edge.
- Comparisons are unsigned, W-bit. There is no arithmetic beyond index and pass counters; idx wraps to 0 on leaving LOAD and leaving OUT.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, state IDLE, buf all 0, counters 0.
- Reset asserted mid-frame in any state discards the frame. The first cycle after release is IDLE.
- Latency: if the last input handshake is at edge t, SORT occupies cycles t+1..t+N and out_valid first rises at t+N+1.
- in_ready and out_valid are never high together.
- Under backpressure (out_valid && !out_ready), out_data holds and idx holds.
- in_valid is ignored while in_ready=0. out_ready is ignored while out_valid=0.
- No back-to-back overlap: the next frame's first word is accepted no earlier than the cycle after the last output handshake.
- N=2: SORT is 2 cycles; the odd pass is empty.

## Configuration
- ODD_EVEN_SORT_EARLY_EXIT_EN defined: a swap_seen flag per pass. SORT exits after two consecutive passes with no swap, or after N passes, whichever is first. Minimum SORT length is 2 cycles.
- Undefined: SORT is always exactly N cycles and no swap_seen logic exists.
- Result data is identical either way.

## Structure
- Package odd_even_sort_pkg holds:
  - state enum (S_IDLE, S_LOAD, S_SORT, S_OUT);
  - mode constants (MODE_ASC=0, MODE_DESC=1, MODE_ODD_FIRST=2, MODE_PARITY_GRP=3).
- Sub-module cmp_swap_unit: combinational, parameter W, inputs a, b, mode; outputs lo, hi, swapped. It is instantiated N-1 times, once per adjacent pair, and gated by pass parity.

## Test plan
All tests use N=8, W=4, macro undefined unless stated.
- mode 0, load 5,3,7,1,6,0,2,4 → out 0,1,2,3,4,5,6,7; out_valid rises 9 cycles after last input handshake.
- mode 1, same input → 7,6,5,4,3,2,1,0.
- mode 2, load 2,4,1,3,6,5,8,7 → 1,3,5,7,2,4,6,8.
- mode 3:
  - load 7,2,5,4,3,6,1,8 → unchanged, since all pairs are mixed parity;
  - load 7,5,3,1,15,13,11,9 → 1,3,5,7,9,11,13,15.
- Backpressure and reset:
  - out_ready held low 3 cycles at idx 2 → out_data stable at buf[2]; in_ready stays 0 until the 8th output handshake.
  - rst pulsed during SORT → out_valid=0, busy=0, in_ready=1 after release.
- ODD_EVEN_SORT_EARLY_EXIT_EN defined, mode 0, load 0..7 presorted → out_valid rises 3 cycles after last input handshake; output 0..7.

Source files
------------

// File: rtl/odd_even_sort_pkg.sv
// Shared types and mode encodings for the odd-even transposition sort engine.
package odd_even_sort_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_OUT
  } state_t;

  localparam logic [1:0] MODE_ASC        = 2'd0;
  localparam logic [1:0] MODE_DESC       = 2'd1;
  localparam logic [1:0] MODE_ODD_FIRST  = 2'd2;
  localparam logic [1:0] MODE_PARITY_GRP = 2'd3;

endpackage

// File: rtl/odd_even_sort_engine_cmp_swap_unit.sv
// Combinational compare-swap cell: decides whether the pair (a,b) is out of
// order for the selected mode and emits the (possibly exchanged) pair.
module cmp_swap_unit
  import odd_even_sort_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         swapped
);

  always_comb begin
    swapped = 1'b0;
    case (mode)
      MODE_ASC:       swapped = (a > b);
      MODE_DESC:      swapped = (a < b);
      MODE_ODD_FIRST: swapped = !a[0] && b[0];
      // Odd values ascend, even values descend, parity classes never cross.
      default:        swapped = (a[0] && b[0] && (a > b)) ||
                                (!a[0] && !b[0] && (a < b));
    endcase
    lo = swapped ? b : a;
    hi = swapped ? a : b;
  end

endmodule

// File: rtl/odd_even_sort_engine.sv
// Frame sorter: serial load, odd-even transposition sort in place, serial
// unload. Define ODD_EVEN_SORT_EARLY_EXIT_EN to stop after two clean passes.
module odd_even_sort_engine
  import odd_even_sort_pkg::*;
#(
  parameter int W = 4,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(N) + 1;

  state_t          state_reg;
  logic [1:0]      mode_reg;
  logic [IW-1:0]   idx_reg;
  logic [PW-1:0]   pass_reg;
  logic [W-1:0]    data_reg [N];

  logic [W-1:0]    lo_w [N-1];
  logic [W-1:0]    hi_w [N-1];
  logic [W-1:0]    pass_data [N];
  logic            sort_done;

`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
  logic [N-2:0]    swapped_w;
  logic            swap_seen;
  logic [1:0]      clean_reg;
`endif

  generate
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_cell
      cmp_swap_unit #(.W(W)) u_cell (
        .a       (data_reg[gi]),
        .b       (data_reg[gi+1]),
        .mode    (mode_reg),
        .lo      (lo_w[gi]),
        .hi      (hi_w[gi]),
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
        .swapped (swapped_w[gi])
`else
        .swapped ()
`endif
      );
    end
  endgenerate

  // Only cells whose left index matches the pass parity take part.
  always_comb begin
    for (int i = 0; i < N; i++) pass_data[i] = data_reg[i];
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(pass_reg[0])) begin
        pass_data[i]   = lo_w[i];
        pass_data[i+1] = hi_w[i];
      end
    end
  end

`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
  always_comb begin
    swap_seen = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if ((i % 2) == int'(pass_reg[0])) swap_seen = swap_seen | swapped_w[i];
    end
  end
  assign sort_done = (pass_reg == PW'(N)) || (clean_reg == 2'd2);
`else
  assign sort_done = (pass_reg == PW'(N));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      mode_reg  <= MODE_ASC;
      idx_reg   <= '0;
      pass_reg  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < N; i++) data_reg[i] <= '0;
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
      clean_reg <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            data_reg[0] <= in_data;
            mode_reg    <= mode;
            idx_reg     <= IW'(1);
            state_reg   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            data_reg[idx_reg] <= in_data;
            if (idx_reg == IW'(N - 1)) begin
              idx_reg   <= '0;
              pass_reg  <= '0;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              state_reg <= S_SORT;
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
              clean_reg <= '0;
`endif
            end else begin
              idx_reg <= idx_reg + IW'(1);
            end
          end
        end
        S_SORT: begin
          if (sort_done) begin
            pass_reg  <= '0;
            out_valid <= 1'b1;
            out_data  <= data_reg[0];
            state_reg <= S_OUT;
          end else begin
            for (int i = 0; i < N; i++) data_reg[i] <= pass_data[i];
            pass_reg <= pass_reg + PW'(1);
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
            if (swap_seen)              clean_reg <= '0;
            else if (clean_reg != 2'd2) clean_reg <= clean_reg + 2'd1;
`endif
          end
        end
        default: begin
          if (out_ready) begin
            if (idx_reg == IW'(N - 1)) begin
              idx_reg   <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              idx_reg  <= idx_reg + IW'(1);
              out_data <= data_reg[idx_reg + IW'(1)];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odd_even_sort_engine.sv
// Directed table-driven bench for odd_even_sort_engine (N=8, W=4).
module tb_odd_even_sort_engine;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int errors = 0;
  int checks = 0;

  odd_even_sort_engine #(.W(4), .N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element 0 is the most significant nibble, so hex reads left to right.
  typedef struct packed {
    logic [1:0]  m;
    logic [31:0] din;
    logic [31:0] dout;
    logic        presorted;
    logic [7:0]  stall_idx;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nib(input logic [31:0] v, input int i);
    return v[31-4*i -: 4];
  endfunction

  task automatic send_frame(input logic [1:0] m, input logic [31:0] d);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = nib(d, i);
      mode     = (i == 0) ? m : ~m;
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic recv_frame(input logic [31:0] exp, input int stall, output logic [31:0] got);
    got = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("bp_data", {28'd0, out_data}, {28'd0, nib(exp, i)});
          chk("bp_valid", {31'd0, out_valid}, 32'd1);
          chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
      end
      out_ready = 1'b1;
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("in_ready_out", {31'd0, in_ready}, 32'd0);
      chk("busy_out", {31'd0, busy}, 32'd1);
      chk("out_data", {28'd0, out_data}, {28'd0, nib(exp, i)});
      got[31-4*i -: 4] = out_data;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_out_data", {28'd0, out_data}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] got;

    vecs[0] = '{m: 2'd0, din: 32'h53716024, dout: 32'h01234567, presorted: 1'b0, stall_idx: 8'd255};
    vecs[1] = '{m: 2'd1, din: 32'h53716024, dout: 32'h76543210, presorted: 1'b0, stall_idx: 8'd255};
    vecs[2] = '{m: 2'd2, din: 32'h24136587, dout: 32'h13572468, presorted: 1'b0, stall_idx: 8'd255};
    vecs[3] = '{m: 2'd3, din: 32'h72543618, dout: 32'h72543618, presorted: 1'b0, stall_idx: 8'd255};
    vecs[4] = '{m: 2'd3, din: 32'h7531FDB9, dout: 32'h13579BDF, presorted: 1'b0, stall_idx: 8'd255};
    vecs[5] = '{m: 2'd0, din: 32'hF0F08811, dout: 32'h001188FF, presorted: 1'b0, stall_idx: 8'd2};
    vecs[6] = '{m: 2'd0, din: 32'h01234567, dout: 32'h01234567, presorted: 1'b1, stall_idx: 8'd255};
    vecs[7] = '{m: 2'd1, din: 32'h01234567, dout: 32'h76543210, presorted: 1'b0, stall_idx: 8'd255};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].m, vecs[v].din);
      chk("busy_sort", {31'd0, busy}, 32'd1);
      chk("in_ready_sort", {31'd0, in_ready}, 32'd0);
      wait_out(lat);
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
      if (vecs[v].presorted) chk("latency_early", lat, 32'd3);
`else
      chk("latency", lat, 32'd9);
`endif
      recv_frame(vecs[v].dout, int'(vecs[v].stall_idx), got);
      $display("frame %0d mode %0d in %h out %h expected %h", v, vecs[v].m, vecs[v].din, got, vecs[v].dout);
    end

    // Reset in the middle of SORT must drop the frame entirely.
    send_frame(2'd0, 32'h53716024);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_sort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #2;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) begin @(posedge clk); #1; end
    chk("post_rst_stays_idle", {31'd0, out_valid | busy}, 32'd0);
    $display("frame rst mid-sort: busy %0b out_valid %0b in_ready %0b", busy, out_valid, in_ready);

    // Engine must still sort normally after the aborted frame.
    send_frame(2'd1, 32'h24136587);
    wait_out(lat);
    recv_frame(32'h87654321, 255, got);
    $display("frame post-rst mode 1 in 24136587 out %h expected 87654321", got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
